// File: rtl/usb_pkg.sv
// Shared types and constants for the USB transmit path.
package usb_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SYNC,
    DATA,
    CRC,
    STALL,
    EOP_SE0,
    EOP_J
  } usb_tx_state_t;

  localparam logic [15:0] USB_CRC16_POLY = 16'h8005;
  localparam logic [15:0] USB_CRC16_INIT = 16'hFFFF;
  localparam logic [7:0]  USB_SYNC       = 8'h80;

  // One serial CRC16 step: shift left, fold in the polynomial when the feedback bit is set.
  function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic bit_in);
    return {crc[14:0], 1'b0} ^ ((crc[15] ^ bit_in) ? USB_CRC16_POLY : 16'h0000);
  endfunction

endpackage

// File: rtl/usb_crc16_serial.sv
// Bit-serial CRC16 accumulator; clear loads the init value, bit_en folds in one bit.
module usb_crc16_serial
  import usb_pkg::*;
(
  input  logic        clk,
  input  logic        RST,
  input  logic        clear,
  input  logic        bit_en,
  input  logic        bit_in,
  output logic [15:0] crc
);

  logic [15:0] crc_q;

  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      crc_q <= '0;
    end else if (clear) begin
      crc_q <= USB_CRC16_INIT;
    end else if (bit_en) begin
      crc_q <= crc16_step(crc_q, bit_in);
    end
  end

  assign crc = crc_q;

endmodule

// File: rtl/usb_tx_sequencer.sv
// Packet transmit sequencer: SYNC, payload LSB-first, optional CRC16, EOP, one bit per clk.
// Tracks the downstream stuffer's run of ones so its inserted bit never collides with ours.
module usb_tx_sequencer
  import usb_pkg::*;
#(
  parameter logic [7:0]  SYNC_PATTERN = USB_SYNC,
  parameter int unsigned EOP_SE0_CLKS = 2,
  parameter int unsigned EOP_J_CLKS   = 1
) (
  input  logic       clk,
  input  logic       RST,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  input  logic       tx_last,
  input  logic       tx_crc,
  output logic       tx_ready,
  output logic       stuff_bit,
  output logic       stuff_en,
  output logic       line_se0,
  output logic       tx_active,
  output logic       tx_done,
  output logic       tx_err
);

  usb_tx_state_t state_q, state_d;
  usb_tx_state_t ret_q, ret_d;
  logic [3:0]    bit_idx_q, bit_idx_d;
  logic [7:0]    byte_q, byte_d;
  logic          last_q, last_d;
  logic          crc_en_q, crc_en_d;
  logic          pid_q, pid_d;
  logic          abort_q, abort_d;
  logic [2:0]    ones_q, ones_d;
  logic [7:0]    eop_cnt_q, eop_cnt_d;

  logic          crc_clear;
  logic          crc_bit_en;
  logic          cur_bit;
  logic          bit_phase;
  logic [15:0]   crc_val;

  usb_crc16_serial u_crc (
    .clk    (clk),
    .RST    (RST),
    .clear  (crc_clear),
    .bit_en (crc_bit_en),
    .bit_in (cur_bit),
    .crc    (crc_val)
  );

  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      state_q   <= IDLE;
      ret_q     <= IDLE;
      bit_idx_q <= '0;
      byte_q    <= '0;
      last_q    <= 1'b0;
      crc_en_q  <= 1'b0;
      pid_q     <= 1'b0;
      abort_q   <= 1'b0;
      ones_q    <= '0;
      eop_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      ret_q     <= ret_d;
      bit_idx_q <= bit_idx_d;
      byte_q    <= byte_d;
      last_q    <= last_d;
      crc_en_q  <= crc_en_d;
      pid_q     <= pid_d;
      abort_q   <= abort_d;
      ones_q    <= ones_d;
      eop_cnt_q <= eop_cnt_d;
    end
  end

  assign bit_phase = (state_q == SYNC) || (state_q == DATA) || (state_q == CRC);

  always_comb begin
    state_d    = state_q;
    ret_d      = ret_q;
    bit_idx_d  = bit_idx_q;
    byte_d     = byte_q;
    last_d     = last_q;
    crc_en_d   = crc_en_q;
    pid_d      = pid_q;
    abort_d    = abort_q;
    ones_d     = ones_q;
    eop_cnt_d  = eop_cnt_q;
    crc_clear  = 1'b0;
    crc_bit_en = 1'b0;
    cur_bit    = 1'b0;
    tx_ready   = 1'b0;
    stuff_bit  = 1'b0;
    stuff_en   = 1'b0;
    line_se0   = 1'b0;
    tx_active  = 1'b0;
    tx_done    = 1'b0;
    tx_err     = 1'b0;

    unique case (state_q)
      IDLE: begin
        tx_ready = tx_valid;
        if (tx_valid) begin
          byte_d    = tx_data;
          last_d    = tx_last;
          crc_en_d  = tx_crc;
          pid_d     = 1'b1;
          abort_d   = 1'b0;
          bit_idx_d = '0;
          ones_d    = '0;
          crc_clear = 1'b1;
          state_d   = SYNC;
        end
      end
      SYNC: begin
        cur_bit   = SYNC_PATTERN[bit_idx_q[2:0]];
        bit_idx_d = bit_idx_q + 4'd1;
        if (bit_idx_q == 4'd7) begin
          bit_idx_d = '0;
          state_d   = DATA;
        end
      end
      DATA: begin
        cur_bit    = byte_q[bit_idx_q[2:0]];
        crc_bit_en = !pid_q;
        bit_idx_d  = bit_idx_q + 4'd1;
        if (bit_idx_q == 4'd7) begin
          bit_idx_d = '0;
          if (last_q) begin
            state_d = crc_en_q ? CRC : EOP_SE0;
          end else begin
            tx_ready = 1'b1;
            if (tx_valid) begin
              byte_d = tx_data;
              last_d = tx_last;
              pid_d  = 1'b0;
            end else begin
              tx_err  = 1'b1;
              abort_d = 1'b1;
              state_d = EOP_SE0;
            end
          end
        end
      end
      CRC: begin
        // Complemented CRC goes out MSB first; ~idx maps 0..15 onto bits 15..0.
        cur_bit   = ~crc_val[~bit_idx_q];
        bit_idx_d = bit_idx_q + 4'd1;
        if (bit_idx_q == 4'd15) begin
          state_d = EOP_SE0;
        end
      end
      STALL: begin
        tx_active = 1'b1;
        ones_d    = '0;
        state_d   = ret_q;
      end
      EOP_SE0: begin
        tx_active = 1'b1;
        line_se0  = 1'b1;
        eop_cnt_d = eop_cnt_q + 8'd1;
        if (eop_cnt_q == 8'(EOP_SE0_CLKS - 1)) begin
          eop_cnt_d = '0;
          state_d   = EOP_J;
        end
      end
      EOP_J: begin
        tx_active = 1'b1;
        eop_cnt_d = eop_cnt_q + 8'd1;
        if (eop_cnt_q == 8'(EOP_J_CLKS - 1)) begin
          eop_cnt_d = '0;
          tx_done   = !abort_q;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // A sixth consecutive one means the stuffer inserts a zero next cycle; park in STALL.
    if (bit_phase) begin
      stuff_en  = 1'b1;
      stuff_bit = cur_bit;
      tx_active = 1'b1;
      if (cur_bit) begin
        if (ones_q == 3'd5) begin
          ones_d  = '0;
          ret_d   = state_d;
          state_d = STALL;
        end else begin
          ones_d = ones_q + 3'd1;
        end
      end else begin
        ones_d = '0;
      end
    end

    if (RST) begin
      tx_ready = 1'b0;
      tx_err   = 1'b0;
    end
  end

endmodule

// File: tb/tb_usb_tx_sequencer.sv
// Scoreboard bench for usb_tx_sequencer: a packet-level model queues the expected per-cycle
// outputs and an independent monitor pops and compares them while the packet is on the line.
module tb_usb_tx_sequencer;

  logic       clk = 1'b0;
  logic       RST;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic       tx_last;
  logic       tx_crc;
  logic       tx_ready;
  logic       stuff_bit;
  logic       stuff_en;
  logic       line_se0;
  logic       tx_active;
  logic       tx_done;
  logic       tx_err;

  always #5 clk = ~clk;

  usb_tx_sequencer dut (
    .clk       (clk),
    .RST       (RST),
    .tx_valid  (tx_valid),
    .tx_data   (tx_data),
    .tx_last   (tx_last),
    .tx_crc    (tx_crc),
    .tx_ready  (tx_ready),
    .stuff_bit (stuff_bit),
    .stuff_en  (stuff_en),
    .line_se0  (line_se0),
    .tx_active (tx_active),
    .tx_done   (tx_done),
    .tx_err    (tx_err)
  );

  typedef struct packed {
    logic se;
    logic sb;
    logic se0;
    logic done;
    logic err;
    logic rdy;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_got;
  exp_t mon_want;
  int   checks   = 0;
  int   failures = 0;
  bit   mon_en   = 1'b0;

  task automatic check(input bit ok, input string name, input logic [31:0] got,
                       input logic [31:0] want);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s got=%0h want=%0h t=%0t", name, got, want, $time);
    end
  endtask

  // CRC16 over every byte after the PID, returned already complemented.
  function automatic logic [15:0] ref_crc(input logic [7:0] b[4], input int n);
    logic [15:0] c;
    logic        fb;
    c = 16'hFFFF;
    for (int i = 1; i < n; i++) begin
      for (int k = 0; k < 8; k++) begin
        fb = c[15] ^ b[i][k];
        c  = {c[14:0], 1'b0};
        if (fb) c = c ^ 16'h8005;
      end
    end
    return ~c;
  endfunction

  task automatic push_exp(input logic se, input logic sb, input logic se0, input logic done,
                          input logic err, input logic rdy);
    exp_t e;
    e.se   = se;
    e.sb   = sb;
    e.se0  = se0;
    e.done = done;
    e.err  = err;
    e.rdy  = rdy;
    exp_q.push_back(e);
  endtask

  // und: index of the byte whose bit-7 handshake sees no data (-1: none).
  task automatic build_expected(input logic [7:0] b[4], input int n, input bit crc,
                                input int und);
    logic        bits[$];
    logic        rdys[$];
    logic        errs[$];
    logic [7:0]  sync;
    logic [15:0] c;
    logic        r;
    int          nb;
    int          run;
    sync = 8'h80;
    for (int k = 0; k < 8; k++) begin
      bits.push_back(sync[k]);
      rdys.push_back(1'b0);
      errs.push_back(1'b0);
    end
    nb = (und >= 0) ? und + 1 : n;
    for (int i = 0; i < nb; i++) begin
      for (int k = 0; k < 8; k++) begin
        r = (k == 7) && (i != n - 1);
        bits.push_back(b[i][k]);
        rdys.push_back(r);
        errs.push_back(r && (i == und));
      end
    end
    if (crc && und < 0) begin
      c = ref_crc(b, n);
      for (int k = 15; k >= 0; k--) begin
        bits.push_back(c[k]);
        rdys.push_back(1'b0);
        errs.push_back(1'b0);
      end
    end
    run = 0;
    for (int j = 0; j < bits.size(); j++) begin
      push_exp(1'b1, bits[j], 1'b0, 1'b0, errs[j], rdys[j]);
      run = bits[j] ? run + 1 : 0;
      if (run == 6) begin
        push_exp(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        run = 0;
      end
    end
    for (int j = 0; j < 2; j++) push_exp(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    push_exp(1'b0, 1'b0, 1'b0, (und < 0), 1'b0, 1'b0);
  endtask

  always @(negedge clk) begin
    if (!RST && mon_en && (tx_active || stuff_en || line_se0 || tx_done || tx_err)) begin
      mon_got = {stuff_en, stuff_bit, line_se0, tx_done, tx_err, tx_ready};
      check(exp_q.size() > 0, "activity_expected", 32'(mon_got), 32'(0));
      if (exp_q.size() > 0) begin
        mon_want = exp_q.pop_front();
        check(mon_got == mon_want, "seq_out", 32'(mon_got), 32'(mon_want));
      end
    end
  end

  task automatic run_packet(input logic [7:0] b[4], input int n, input bit crc, input int und,
                            input int abort_at);
    int next;
    bit acc;
    bit done_ok;
    build_expected(b, n, crc, und);
    @(posedge clk);
    #1;
    tx_valid = 1'b1;
    tx_data  = b[0];
    tx_last  = (n == 1);
    tx_crc   = crc;
    #1;
    check(tx_ready == 1'b1, "idle_ready", 32'(tx_ready), 32'(1));
    @(posedge clk);
    #1;
    check({tx_active, stuff_en, stuff_bit} == 3'b110, "first_sync_bit",
          32'({tx_active, stuff_en, stuff_bit}), 32'(3'b110));
    next     = 1;
    tx_valid = (n > 1) && (und != 0);
    tx_data  = 8'($urandom);
    tx_last  = 1'($urandom);
    tx_crc   = 1'($urandom);
    done_ok  = 1'b0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      if (cyc == abort_at) begin
        check(tx_active == 1'b1, "pre_rst_active", 32'(tx_active), 32'(1));
        RST = 1'b1;
        #1;
        check({tx_ready, stuff_en, stuff_bit, line_se0, tx_active, tx_done, tx_err} == 7'b0,
              "rst_mid_outputs",
              32'({tx_ready, stuff_en, stuff_bit, line_se0, tx_active, tx_done, tx_err}),
              32'(0));
        exp_q.delete();
        tx_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        RST = 1'b0;
        return;
      end
      @(negedge clk);
      acc = tx_valid && tx_ready;
      if (acc) begin
        tx_data = b[next];
        tx_last = (next == n - 1);
      end
      @(posedge clk);
      #1;
      if (acc) begin
        next++;
        tx_valid = (next < n) && (next - 1 != und);
        tx_data  = 8'($urandom);
        tx_last  = 1'($urandom);
      end
      if (exp_q.size() == 0) begin
        done_ok = 1'b1;
        break;
      end
    end
    check(done_ok, "packet_complete", 32'(done_ok), 32'(1));
    if (done_ok) check(tx_active == 1'b0, "active_drops", 32'(tx_active), 32'(0));
    exp_q.delete();
    tx_valid = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog_timeout t=%0t", $time);
    $fatal(1);
  end

  initial begin
    logic [7:0] b[4];
    int         n;
    int         und;
    bit         crc;

    RST      = 1'b1;
    tx_valid = 1'b1;
    tx_data  = 8'hD2;
    tx_last  = 1'b1;
    tx_crc   = 1'b0;
    mon_en   = 1'b1;
    repeat (4) begin
      @(negedge clk);
      check({tx_ready, stuff_en, stuff_bit, line_se0, tx_active, tx_done, tx_err} == 7'b0,
            "rst_hold_outputs",
            32'({tx_ready, stuff_en, stuff_bit, line_se0, tx_active, tx_done, tx_err}), 32'(0));
    end
    @(posedge clk);
    #1;
    RST      = 1'b0;
    tx_valid = 1'b0;
    #1;
    check(tx_ready == 1'b0, "idle_ready_low", 32'(tx_ready), 32'(0));

    b = '{8'hD2, 8'h00, 8'h00, 8'h00};
    run_packet(b, 1, 1'b0, -1, -1);
    b = '{8'hFF, 8'h00, 8'h00, 8'h00};
    run_packet(b, 1, 1'b0, -1, -1);
    b = '{8'hC3, 8'h00, 8'h00, 8'h00};
    run_packet(b, 1, 1'b1, -1, -1);
    b = '{8'h4B, 8'h00, 8'h00, 8'h00};
    run_packet(b, 2, 1'b1, 0, -1);
    b = '{8'hFF, 8'hFF, 8'h00, 8'h00};
    run_packet(b, 2, 1'b0, -1, -1);
    run_packet(b, 2, 1'b1, -1, 19);
    b = '{8'hC3, 8'h01, 8'h02, 8'h03};
    run_packet(b, 4, 1'b1, -1, -1);

    for (int p = 0; p < 30; p++) begin
      n = int'($urandom_range(1, 4));
      for (int i = 0; i < 4; i++) begin
        b[i] = ($urandom_range(0, 2) == 0) ? 8'hFF : 8'($urandom);
      end
      crc = 1'($urandom_range(0, 1));
      und = -1;
      if (n > 1 && $urandom_range(0, 3) == 0) und = int'($urandom_range(0, n - 2));
      run_packet(b, n, crc, und, -1);
    end

    repeat (2) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
